instruction_loader: RTL and testbench

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

---
 rtl/instruction_loader_if.sv | 29 ++
 rtl/instruction_loader.sv | 140 ++++++++++++++
 tb/tb_instruction_loader.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_loader_if.sv
// Handshake and byte-write bus between a word source, the instruction loader
// and the instruction memory.
interface instruction_loader_if #(
  parameter int unsigned N = 32
);
  logic          start;
  logic [13:0]   base_addr;
  logic          word_valid;
  logic [N-1:0]  word_data;
  logic          word_last;
  logic          word_ready;
  logic          mem_we;
  logic [13:0]   mem_addr;
  logic [7:0]    mem_wdata;
  logic          busy;
  logic          done;
  logic          overflow;
  logic [11:0]   word_count;

  modport master (
    output start, base_addr, word_valid, word_data, word_last,
    input  word_ready, mem_we, mem_addr, mem_wdata, busy, done, overflow, word_count
  );

  modport slave (
    input  start, base_addr, word_valid, word_data, word_last,
    output word_ready, mem_we, mem_addr, mem_wdata, busy, done, overflow, word_count
  );
endinterface

// File: rtl/instruction_loader.sv
// Accepts N-bit instruction words and writes each one to instruction memory
// as four little-endian byte writes, with bounds checking against MEM_BYTES.
module instruction_loader #(
  parameter int unsigned N         = 32,
  parameter int unsigned MEM_BYTES = 1024
) (
  input logic               clk,
  input logic               rst_n,
  instruction_loader_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        r_state;
  logic [13:0]   r_ptr;
  logic [1:0]    r_idx;
  logic [N-1:0]  r_word;
  logic          r_last;
  logic [11:0]   r_count;
  logic          r_ovf;
  logic [13:0]   r_mem_addr;
  logic [7:0]    r_mem_wdata;

  state_t        w_state_nxt;
  logic [13:0]   w_ptr_nxt;
  logic [1:0]    w_idx_nxt;
  logic [N-1:0]  w_word_nxt;
  logic          w_last_nxt;
  logic [11:0]   w_count_nxt;
  logic          w_ovf_nxt;
  logic [13:0]   w_addr_nxt;
  logic [7:0]    w_wdata_nxt;
  logic [N-1:0]  w_shifted;
  logic [31:0]   w_ptr_end;

  assign w_ptr_end = {18'b0, r_ptr} + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_idx       <= '0;
      r_word      <= '0;
      r_last      <= 1'b0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_idx       <= w_idx_nxt;
      r_word      <= w_word_nxt;
      r_last      <= w_last_nxt;
      r_count     <= w_count_nxt;
      r_ovf       <= w_ovf_nxt;
      r_mem_addr  <= w_addr_nxt;
      r_mem_wdata <= w_wdata_nxt;
    end
  end

  // The byte address/data registers are loaded with the values for the next
  // WRITE cycle, so they are valid exactly while the FSM sits in WRITE and
  // simply hold afterwards.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_idx_nxt   = r_idx;
    w_word_nxt  = r_word;
    w_last_nxt  = r_last;
    w_count_nxt = r_count;
    w_ovf_nxt   = r_ovf;
    w_addr_nxt  = r_mem_addr;
    w_wdata_nxt = r_mem_wdata;
    w_shifted   = '0;

    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_ptr_nxt   = bus.base_addr & 14'h3FFC;
          w_count_nxt = '0;
          w_ovf_nxt   = 1'b0;
          w_state_nxt = ACCEPT;
        end
      end

      ACCEPT: begin
        if (bus.word_valid) begin
          if (w_ptr_end > MEM_BYTES) begin
            w_ovf_nxt   = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_word_nxt  = bus.word_data;
            w_last_nxt  = bus.word_last;
            w_idx_nxt   = '0;
            w_addr_nxt  = r_ptr;
            w_wdata_nxt = bus.word_data[7:0];
            w_state_nxt = WRITE;
          end
        end
      end

      WRITE: begin
        if (r_idx == 2'd3) begin
          w_ptr_nxt   = r_ptr + 14'd4;
          w_count_nxt = r_count + 12'd1;
          w_state_nxt = r_last ? DONE : ACCEPT;
        end else begin
          w_idx_nxt   = r_idx + 2'd1;
          w_addr_nxt  = r_ptr + {12'b0, w_idx_nxt};
          w_shifted   = r_word >> {w_idx_nxt, 3'b000};
          w_wdata_nxt = w_shifted[7:0];
        end
      end

      DONE: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.word_ready = (r_state == ACCEPT);
  assign bus.mem_we     = (r_state == WRITE);
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.busy       = (r_state != IDLE);
  assign bus.done       = (r_state == DONE);
  assign bus.overflow   = r_ovf;
  assign bus.word_count = r_count;

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: directed table of sessions,
// hand-written reset/start corner cases and randomized sessions vs a model.
module tb_instruction_loader;

  localparam int unsigned MEM = 1024;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  int   done_cnt;

  typedef struct {
    logic [13:0] a;
    logic [7:0]  d;
    int          c;
  } wr_t;

  wr_t wq[$];

  typedef struct {
    logic [13:0] base;
    int unsigned n;
    logic [31:0] w0;
    bit          hold;
    bit          poke;
    int unsigned exp_count;
    bit          exp_ovf;
    logic [13:0] exp_first;
  } vec_t;

  instruction_loader_if #(.N(32)) bus ();

  instruction_loader #(.N(32), .MEM_BYTES(MEM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) wq.push_back('{a: bus.mem_addr, d: bus.mem_wdata, c: cyc});
    if (bus.done === 1'b1) done_cnt = done_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one load session and checks it against a model derived from the
  // addressing and bounds rules: word k lands at aligned_base+4k unless it
  // would cross MEM, in which case it and everything after is dropped.
  task automatic run_session(input logic [13:0] base, input int unsigned n, input logic [31:0] w0,
                             input bit hold, input bit poke, input string tag);
    logic [13:0] al;
    logic [31:0] words[$];
    logic [31:0] tmp;
    wr_t         exp[$];
    int          acc[$];
    int unsigned nfit, ndrive;
    bit          ovf;
    int          budget;
    int          bad;

    al   = base & 14'h3FFC;
    nfit = 0;
    ovf  = 1'b0;
    for (int unsigned k = 0; k < n; k++) words.push_back(w0 + k * 32'h01010101);
    for (int unsigned k = 0; k < n; k++) begin
      if (int'(al) + 4 * (k + 1) > MEM) begin
        ovf = 1'b1;
        break;
      end
      nfit++;
      for (int unsigned b = 0; b < 4; b++) begin
        tmp = words[k] >> (8 * b);
        exp.push_back('{a: 14'(int'(al) + 4 * k + b), d: tmp[7:0], c: 0});
      end
    end
    ndrive = ovf ? nfit + 1 : n;

    @(negedge clk);
    wq.delete();
    done_cnt = 0;
    bus.start     = 1'b1;
    bus.base_addr = base;
    @(posedge clk);
    @(negedge clk);
    bus.start     = 1'b0;
    bus.base_addr = 14'($urandom);
    chk({tag, "/count_cleared"}, 32'(bus.word_count), 32'd0);
    chk({tag, "/ovf_cleared"}, 32'(bus.overflow), 32'd0);

    for (int unsigned k = 0; k < ndrive; k++) begin
      bus.word_valid = 1'b1;
      bus.word_data  = words[k];
      bus.word_last  = (k == n - 1);
      budget = 40;
      while (!bus.word_ready && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      if (!bus.word_ready) begin
        chk({tag, "/ready_timeout"}, 32'(bus.word_ready), 32'd1);
        break;
      end
      if (poke && k == 1) begin
        bus.start     = 1'b1;
        bus.base_addr = 14'h100;
      end
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      acc.push_back(cyc);
      if (!(hold && k + 1 < ndrive)) begin
        bus.word_valid = 1'b0;
        if (!hold) repeat ($urandom_range(0, 6)) @(negedge clk);
      end
    end
    bus.word_valid = 1'b0;
    bus.word_last  = 1'b0;

    budget = 30;
    while (bus.busy && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    repeat (3) @(negedge clk);

    chk({tag, "/busy_end"}, 32'(bus.busy), 32'd0);
    chk({tag, "/nwrites"}, 32'(wq.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < wq.size(); i++)
      chk($sformatf("%s/wr%0d", tag, i), {10'd0, wq[i].a, wq[i].d}, {10'd0, exp[i].a, exp[i].d});
    if (wq.size() >= exp.size() && acc.size() >= nfit) begin
      bad = 0;
      for (int j = 0; j < int'(nfit); j++) begin
        if (wq[4 * j].c != acc[j]) bad++;
        for (int b = 1; b < 4; b++) if (wq[4 * j + b].c != wq[4 * j].c + b) bad++;
      end
      chk({tag, "/wr_timing"}, 32'(bad), 32'd0);
    end
    if (hold)
      for (int j = 1; j < acc.size(); j++)
        chk($sformatf("%s/accept_gap%0d", tag, j), 32'(acc[j] - acc[j - 1]), 32'd5);
    chk({tag, "/word_count"}, 32'(bus.word_count), 32'(nfit));
    chk({tag, "/overflow"}, 32'(bus.overflow), 32'(ovf));
    chk({tag, "/done_pulses"}, 32'(done_cnt), 32'd1);
    if (nfit > 0) begin
      chk({tag, "/addr_hold"}, 32'(bus.mem_addr), 32'(exp[exp.size() - 1].a));
      chk({tag, "/data_hold"}, 32'(bus.mem_wdata), 32'(exp[exp.size() - 1].d));
    end
  endtask

  vec_t vecs[8];

  initial begin
    checks = 0;
    errors = 0;
    done_cnt = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.word_valid = 1'b0;
    bus.word_data = '0;
    bus.word_last = 1'b0;

    vecs[0] = '{14'h010, 1, 32'hDDCCBBAA, 1'b0, 1'b0, 1, 1'b0, 14'h010};
    vecs[1] = '{14'h000, 3, 32'h03020100, 1'b1, 1'b0, 3, 1'b0, 14'h000};
    vecs[2] = '{14'h013, 1, 32'h12345678, 1'b0, 1'b0, 1, 1'b0, 14'h010};
    vecs[3] = '{14'h3FC, 2, 32'hCAFEBABE, 1'b1, 1'b0, 1, 1'b1, 14'h3FC};
    vecs[4] = '{14'h040, 2, 32'h89ABCDEF, 1'b0, 1'b1, 2, 1'b0, 14'h040};
    vecs[5] = '{14'h3F0, 5, 32'h0F0E0D0C, 1'b1, 1'b0, 4, 1'b1, 14'h3F0};
    vecs[6] = '{14'h400, 1, 32'h11111111, 1'b0, 1'b0, 0, 1'b1, 14'h000};
    vecs[7] = '{14'h3FF, 1, 32'hA5A55A5A, 1'b0, 1'b0, 1, 1'b0, 14'h3FC};

    #12;
    chk("rst/word_ready", 32'(bus.word_ready), 32'd0);
    chk("rst/mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst/mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst/mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst/busy", 32'(bus.busy), 32'd0);
    chk("rst/done", 32'(bus.done), 32'd0);
    chk("rst/overflow", 32'(bus.overflow), 32'd0);
    chk("rst/word_count", 32'(bus.word_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_session(vecs[i].base, vecs[i].n, vecs[i].w0, vecs[i].hold, vecs[i].poke,
                  $sformatf("vec%0d", i));
      chk($sformatf("vec%0d/tbl_count", i), 32'(bus.word_count), 32'(vecs[i].exp_count));
      chk($sformatf("vec%0d/tbl_ovf", i), 32'(bus.overflow), 32'(vecs[i].exp_ovf));
      if (vecs[i].exp_count > 0 && wq.size() > 0)
        chk($sformatf("vec%0d/tbl_first", i), 32'(wq[0].a), 32'(vecs[i].exp_first));
    end

    // Reset landing in the third byte write of a word.
    @(negedge clk);
    wq.delete();
    bus.start = 1'b1;
    bus.base_addr = 14'h020;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.word_valid = 1'b1;
    bus.word_data = 32'h44332211;
    bus.word_last = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.word_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid/mem_we", 32'(bus.mem_we), 32'd0);
    chk("rstmid/busy", 32'(bus.busy), 32'd0);
    chk("rstmid/mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rstmid/word_count", 32'(bus.word_count), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rstmid/stays_idle", 32'(bus.busy), 32'd0);
    chk("rstmid/nwrites", 32'(wq.size()), 32'd3);
    if (wq.size() >= 3) chk("rstmid/last_partial", {18'd0, wq[2].a}, 32'h022);
    run_session(14'h020, 1, 32'h44332211, 1'b0, 1'b0, "rstmid_after");

    for (int r = 0; r < 20; r++) begin
      logic [13:0] b;
      if ($urandom_range(0, 1) == 1) b = 14'(MEM - $urandom_range(0, 20));
      else b = 14'($urandom_range(0, MEM - 1));
      run_session(b, $urandom_range(1, 4), $urandom, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
